// File: rtl/uart_frame_rx.sv
// uart_frame_rx: extracts HDR0 HDR1 LEN payload [CHK] frames from a UART byte stream.
// Build option UART_FRAME_CHKSUM_EN adds a trailing mod-256 checksum byte (LEN + payload).
module uart_frame_rx #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned UART_BPS = 115200,
  parameter logic [7:0]  HDR0     = 8'h55,
  parameter logic [7:0]  HDR1     = 8'hAA,
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned TO_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx_done,
  input  logic [7:0] uart_data,
  output logic       pay_valid,
  output logic [7:0] pay_data,
  output logic [7:0] pay_idx,
  output logic [7:0] frame_len,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {S_IDLE, S_H1, S_LEN, S_PAY, S_CHK} state_t;

  // Inter-byte timeout in clocks; 64-bit math keeps TO_BYTES*10*CLK_FREQ from overflowing.
  localparam longint unsigned TO_LIMIT =
    (64'(TO_BYTES) * 64'd10 * 64'(CLK_FREQ)) / 64'(UART_BPS);
  localparam int unsigned     TO_W     = $clog2(TO_LIMIT + 64'd1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TO_LIMIT - 64'd1);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [1:0] ERR_LEN   = 2'd1;
  localparam logic [1:0] ERR_TO    = 2'd3;
`ifdef UART_FRAME_CHKSUM_EN
  localparam logic [1:0] ERR_CHK   = 2'd2;
  logic [7:0] acc;
`endif

  state_t          state;
  logic [7:0]      pay_cnt;
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pay_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      pay_data   <= '0;
      pay_idx    <= '0;
      frame_len  <= '0;
      err_code   <= '0;
      pay_cnt    <= '0;
      to_cnt     <= '0;
`ifdef UART_FRAME_CHKSUM_EN
      acc        <= '0;
`endif
    end else begin
      // NOTE: strobes default low each cycle; later non-blocking writes in this block win.
      pay_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (uart_rx_done) begin
        to_cnt <= '0;
        case (state)
          S_IDLE: if (uart_data == HDR0) state <= S_H1;
          S_H1: begin
            if (uart_data == HDR1)      state <= S_LEN;
            else if (uart_data != HDR0) state <= S_IDLE;
          end
          S_LEN: begin
            if (uart_data == 8'd0 || uart_data > MAX_LEN_B) begin
              frame_err <= 1'b1;
              err_code  <= ERR_LEN;
              state     <= S_IDLE;
            end else begin
              frame_len <= uart_data;
              pay_cnt   <= '0;
`ifdef UART_FRAME_CHKSUM_EN
              acc       <= uart_data;
`endif
              state     <= S_PAY;
            end
          end
          S_PAY: begin
            pay_valid <= 1'b1;
            pay_data  <= uart_data;
            pay_idx   <= pay_cnt;
            pay_cnt   <= pay_cnt + 8'd1;
`ifdef UART_FRAME_CHKSUM_EN
            acc       <= acc + uart_data;
            if (pay_cnt == frame_len - 8'd1) state <= S_CHK;
`else
            if (pay_cnt == frame_len - 8'd1) begin
              frame_done <= 1'b1;
              state      <= S_IDLE;
            end
`endif
          end
`ifdef UART_FRAME_CHKSUM_EN
          S_CHK: begin
            if (uart_data == acc) begin
              frame_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_CHK;
            end
            state <= S_IDLE;
          end
`endif
          default: state <= S_IDLE;
        endcase
      end else if (state != S_IDLE) begin
        // A byte arriving in the expiry cycle takes the branch above instead.
        if (to_cnt == TO_LAST) begin
          frame_err <= 1'b1;
          err_code  <= ERR_TO;
          state     <= S_IDLE;
          to_cnt    <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: frames are built from their byte-level rules and the
// expected strobes per clock are queued alongside the stimulus, then replayed and compared.
module tb_uart_frame_rx;

  localparam int unsigned CLK_FREQ = 50000000;
  localparam int unsigned UART_BPS = 115200;
  localparam logic [7:0]  HDR0     = 8'h55;
  localparam logic [7:0]  HDR1     = 8'hAA;
  localparam int unsigned MAX_LEN  = 16;
  localparam int unsigned TO_BYTES = 4;
  localparam int unsigned TO_LIMIT =
    int'((64'(TO_BYTES) * 64'd10 * 64'(CLK_FREQ)) / 64'(UART_BPS));
`ifdef UART_FRAME_CHKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx_done;
  logic [7:0] uart_data;
  logic       pay_valid;
  logic [7:0] pay_data;
  logic [7:0] pay_idx;
  logic [7:0] frame_len;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;

  uart_frame_rx #(
    .CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .HDR0(HDR0), .HDR1(HDR1),
    .MAX_LEN(MAX_LEN), .TO_BYTES(TO_BYTES)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx_done(uart_rx_done), .uart_data(uart_data),
    .pay_valid(pay_valid), .pay_data(pay_data), .pay_idx(pay_idx),
    .frame_len(frame_len), .frame_done(frame_done), .frame_err(frame_err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pv;
    logic       fd;
    logic       fe;
    logic [7:0] pd;
    logic [7:0] pi;
    logic [1:0] ec;
    logic [7:0] fl;
  } obs_t;

  // Stimulus and expectation queues: one entry per clock cycle.
  bit         q_r[$];
  bit         q_v[$];
  logic [7:0] q_b[$];
  obs_t       q_e[$];

  // Reference model state: what a correct receiver knows about the frame in flight.
  logic [7:0] exp_flen = 8'd0;
  int         cur_len;
  int         cur_idx;
  logic [7:0] cur_sum;
  int         gap_max = 0;

  int n_pass  = 0;
  int n_total = 0;
  int step    = 0;

  function automatic obs_t quiet();
    obs_t q = '0;
    q.fl = exp_flen;
    return q;
  endfunction

  function automatic obs_t masked(obs_t x, obs_t e);
    obs_t m = x;
    if (!e.pv) begin
      m.pd = '0;
      m.pi = '0;
    end
    if (!e.fe) m.ec = '0;
    return m;
  endfunction

  function automatic string fmt(obs_t x);
    return $sformatf("valid=%b done=%b err=%b data=%h idx=%0d code=%0d len=%0d",
                     x.pv, x.fd, x.fe, x.pd, x.pi, x.ec, x.fl);
  endfunction

  task automatic push(input bit r, input bit v, input logic [7:0] b, input obs_t e);
    q_r.push_back(r);
    q_v.push_back(v);
    q_b.push_back(b);
    q_e.push_back(e);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, 8'h00, quiet());
  endtask

  task automatic gap();
    if (gap_max > 0) push_idle($urandom_range(0, gap_max));
  endtask

  // Header plus LEN; returns whether LEN was legal and a payload follows.
  task automatic push_hdr_len(input logic [7:0] len, output bit legal);
    obs_t e;
    gap(); push(1'b0, 1'b1, HDR0, quiet());
    gap(); push(1'b0, 1'b1, HDR1, quiet());
    gap();
    legal = (len != 8'd0) && (int'(len) <= int'(MAX_LEN));
    if (legal) begin
      exp_flen = len;
      cur_len  = int'(len);
      cur_idx  = 0;
      cur_sum  = len;
      push(1'b0, 1'b1, len, quiet());
    end else begin
      e = quiet();
      e.fe = 1'b1;
      e.ec = 2'd1;
      push(1'b0, 1'b1, len, e);
    end
  endtask

  task automatic push_pay(input logic [7:0] b);
    obs_t e;
    gap();
    e = quiet();
    e.pv = 1'b1;
    e.pd = b;
    e.pi = 8'(cur_idx);
    cur_sum = cur_sum + b;
    cur_idx++;
    if (!CHK_EN && cur_idx == cur_len) e.fd = 1'b1;
    push(1'b0, 1'b1, b, e);
  endtask

  // Checksum byte; without the checksum build it lands in IDLE and must be ignored.
  task automatic push_chk(input logic [7:0] b);
    obs_t e;
    gap();
    e = quiet();
    if (CHK_EN) begin
      if (b == cur_sum) e.fd = 1'b1;
      else begin
        e.fe = 1'b1;
        e.ec = 2'd2;
      end
      push(1'b0, 1'b1, b, e);
    end else if (b != HDR0) begin
      push(1'b0, 1'b1, b, e);
    end
  endtask

  task automatic push_rand_frame(input logic [7:0] len, input bit corrupt);
    bit legal;
    push_hdr_len(len, legal);
    if (legal) begin
      for (int i = 0; i < int'(len); i++) push_pay(8'($urandom_range(0, 255)));
      push_chk(corrupt ? (cur_sum ^ 8'($urandom_range(1, 255))) : cur_sum);
    end
  endtask

  task automatic tick_next(output obs_t o, output obs_t e);
    @(negedge clk);
    rst          = q_r.pop_front();
    uart_rx_done = q_v.pop_front();
    uart_data    = q_b.pop_front();
    e            = q_e.pop_front();
    @(posedge clk);
    #1;
    o = '{pay_valid, frame_done, frame_err, pay_data, pay_idx, err_code, frame_len};
    uart_rx_done = 1'b0;
    rst          = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    uart_rx_done = 1'b1;
    uart_data = HDR0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({pay_valid, frame_done, frame_err} !== 3'b000)
      $display("FAIL reset_strobes: got %b, expected 000", {pay_valid, frame_done, frame_err});
    else n_pass++;
    n_total++;
    if ({pay_data, pay_idx, frame_len} !== 24'h0)
      $display("FAIL reset_regs: got data=%h idx=%h len=%h, expected 0", pay_data, pay_idx, frame_len);
    else n_pass++;
    n_total++;
    if (err_code !== 2'd0) $display("FAIL reset_err_code: got %0d, expected 0", err_code);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    uart_rx_done = 1'b0;
  endtask

  task automatic test_good_frame();
    obs_t o, e;
    bit legal;
    push_hdr_len(8'h03, legal);
    push_pay(8'h11); push_pay(8'h22); push_pay(8'h33);
    push_chk(8'h69);
    push_idle(2);
    push_hdr_len(8'h01, legal);
    push_pay(8'h5A);
    push_chk(8'h5B);
    push_idle(2);
    while (q_b.size() != 0) begin
      tick_next(o, e);
      n_total++;
      if (masked(o, e) !== masked(e, e))
        $display("FAIL good_frame step %0d: got %s, expected %s", step, fmt(o), fmt(e));
      else n_pass++;
      step++;
    end
  endtask

  task automatic test_bad_frames();
    obs_t o, e;
    bit legal;
    push_hdr_len(8'h02, legal);
    push_pay(8'h01); push_pay(8'h02);
    push_chk(8'h00);
    push_rand_frame(8'h04, 1'b0);
    push_hdr_len(8'h00, legal);
    push_idle(3);
    push_hdr_len(8'(MAX_LEN + 1), legal);
    push_idle(3);
    push_rand_frame(8'(MAX_LEN), 1'b0);
    while (q_b.size() != 0) begin
      tick_next(o, e);
      n_total++;
      if (masked(o, e) !== masked(e, e))
        $display("FAIL bad_frames step %0d: got %s, expected %s", step, fmt(o), fmt(e));
      else n_pass++;
      step++;
    end
  endtask

  task automatic test_headers();
    obs_t o, e;
    bit legal;
    // Repeated HDR0 keeps waiting for HDR1.
    push(1'b0, 1'b1, HDR0, quiet());
    push_hdr_len(8'h01, legal);
    push_pay(8'h7E);
    push_chk(8'h7F);
    // HDR0 then a foreign byte drops back to IDLE, so the following bytes are ignored.
    push(1'b0, 1'b1, HDR0, quiet());
    push(1'b0, 1'b1, 8'h12, quiet());
    push(1'b0, 1'b1, HDR1, quiet());
    push(1'b0, 1'b1, 8'h03, quiet());
    push(1'b0, 1'b1, 8'h44, quiet());
    push_rand_frame(8'h02, 1'b0);
    while (q_b.size() != 0) begin
      tick_next(o, e);
      n_total++;
      if (masked(o, e) !== masked(e, e))
        $display("FAIL headers step %0d: got %s, expected %s", step, fmt(o), fmt(e));
      else n_pass++;
      step++;
    end
  endtask

  task automatic test_timeout();
    obs_t o, e;
    bit legal;
    push_hdr_len(8'h04, legal);
    push_pay(8'h01);
    push_idle(TO_LIMIT - 1);
    e = quiet();
    e.fe = 1'b1;
    e.ec = 2'd3;
    push(1'b0, 1'b0, 8'h00, e);
    push_idle(3);
    // A byte landing exactly in the expiry cycle wins over the timeout.
    push_hdr_len(8'h02, legal);
    push_pay(8'h01);
    push_idle(TO_LIMIT - 1);
    push_pay(8'h02);
    push_chk(cur_sum);
    push_idle(3);
    while (q_b.size() != 0) begin
      tick_next(o, e);
      n_total++;
      if (masked(o, e) !== masked(e, e))
        $display("FAIL timeout step %0d: got %s, expected %s", step, fmt(o), fmt(e));
      else n_pass++;
      step++;
    end
  endtask

  task automatic test_reset_mid_frame();
    obs_t o, e;
    bit legal;
    push_hdr_len(8'h02, legal);
    push_pay(8'h01);
    exp_flen = 8'd0;
    push(1'b1, 1'b1, 8'h02, quiet());
    push(1'b0, 1'b1, 8'h02, quiet());
    push_idle(2);
    while (q_b.size() != 0) begin
      tick_next(o, e);
      n_total++;
      if (masked(o, e) !== masked(e, e))
        $display("FAIL reset_mid_frame step %0d: got %s, expected %s", step, fmt(o), fmt(e));
      else n_pass++;
      step++;
    end
    n_total++;
    if ({pay_data, pay_idx, err_code} !== 18'h0)
      $display("FAIL reset_mid_frame_regs: got data=%h idx=%h code=%0d, expected 0",
               pay_data, pay_idx, err_code);
    else n_pass++;
    push_rand_frame(8'h05, 1'b0);
    push_idle(2);
    while (q_b.size() != 0) begin
      tick_next(o, e);
      n_total++;
      if (masked(o, e) !== masked(e, e))
        $display("FAIL reset_recover step %0d: got %s, expected %s", step, fmt(o), fmt(e));
      else n_pass++;
      step++;
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    int r;
    logic [7:0] len;
    gap_max = 3;
    repeat (12) begin
      r = $urandom_range(0, 9);
      if (r == 0)      len = 8'd0;
      else if (r == 1) len = 8'($urandom_range(MAX_LEN + 1, 255));
      else if (r == 2) len = 8'(MAX_LEN);
      else             len = 8'($urandom_range(1, MAX_LEN));
      push_rand_frame(len, $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) begin
        logic [7:0] junk = 8'($urandom_range(0, 255));
        if (junk == HDR0) junk = 8'h56;
        push(1'b0, 1'b1, junk, quiet());
      end
    end
    gap_max = 0;
    while (q_b.size() != 0) begin
      tick_next(o, e);
      n_total++;
      if (masked(o, e) !== masked(e, e))
        $display("FAIL random step %0d: got %s, expected %s", step, fmt(o), fmt(e));
      else n_pass++;
      step++;
    end
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    gap_max = 0;
    push_rand_frame(8'($urandom_range(1, MAX_LEN)), 1'b0);
    push_rand_frame(8'($urandom_range(1, MAX_LEN)), 1'b1);
    push_rand_frame(8'd0, 1'b0);
    push_rand_frame(8'd1, 1'b0);
    push_rand_frame(8'($urandom_range(1, MAX_LEN)), 1'b0);
    push_idle(2);
    while (q_b.size() != 0) begin
      tick_next(o, e);
      n_total++;
      if (masked(o, e) !== masked(e, e))
        $display("FAIL back_to_back step %0d: got %s, expected %s", step, fmt(o), fmt(e));
      else n_pass++;
      step++;
    end
  endtask

  initial begin
    rst = 1'b1;
    uart_rx_done = 1'b0;
    uart_data = 8'h00;
    test_reset();
    test_good_frame();
    test_bad_frames();
    test_headers();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000: system clock frequency in Hz.
REQ-002 Parameter UART_BPS, default 115200: serial bit rate, used only to size the timeout.
REQ-003 Parameter HDR0, default 8'h55: first header byte.
REQ-004 Parameter HDR1, default 8'hAA: second header byte.
REQ-005 Parameter MAX_LEN, default 16: largest legal payload length, range 1..255.
REQ-006 Parameter TO_BYTES, default 4: inter-byte timeout, in character times of 10 bits each.
REQ-007 clk  input  1  system clock; the block has one clock.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 uart_rx_done  input  1  one-cycle strobe from the UART receiver marking a new byte.
REQ-010 uart_data  input  8  received byte, valid in the cycle uart_rx_done is high.
REQ-011 pay_valid  output  1  one-cycle strobe for each payload byte.
REQ-012 pay_data  output  8  payload byte, valid with pay_valid.
REQ-013 pay_idx  output  8  zero-based index of pay_data within the frame.
REQ-014 frame_len  output  8  LEN field of the current frame, held until the next LEN byte is accepted.
REQ-015 frame_done  output  1  one-cycle strobe when a frame completes without error.
REQ-016 frame_err  output  1  one-cycle strobe when a frame is aborted.
REQ-017 err_code  output  2  abort cause, valid with frame_err and held afterwards: 1 = bad LEN, 2 = checksum mismatch, 3 = timeout.

Function
REQ-018 Frame format on the byte stream: HDR0, HDR1, LEN, LEN payload bytes, then CHK.
REQ-019 FSM states: IDLE, H1, LEN, PAY, CHK; a state advances only in a cycle where uart_rx_done is high.
REQ-020 IDLE: a byte equal to HDR0 goes to H1; any other byte stays in IDLE and produces no output.
REQ-021 H1: HDR1 goes to LEN; HDR0 stays in H1; any other byte goes to IDLE; no error is flagged in any case.
REQ-022 LEN: 0 or a value above MAX_LEN gives frame_err with err_code=1 and returns to IDLE.
REQ-023 LEN: a legal value is latched into frame_len, the checksum accumulator is set to LEN, and the FSM goes to PAY.
REQ-024 PAY: each byte gives pay_valid, pay_data and pay_idx exactly 1 cycle after its uart_rx_done.
REQ-025 PAY: each byte is added to the checksum modulo 256.
REQ-026 PAY: after byte index LEN-1 the FSM goes to CHK.
REQ-027 CHK: a byte equal to the accumulator gives frame_done; otherwise frame_err with err_code=2; both return to IDLE.
REQ-028 All strobes are registered, with latency 1 cycle from the causing uart_rx_done.
REQ-029 frame_done and frame_err are never high in the same cycle.
REQ-030 Timeout: in any state other than IDLE, a counter of clocks since the last uart_rx_done runs.
REQ-031 Timeout: the limit is TO_BYTES*10*CLK_FREQ/UART_BPS clocks, evaluated at elaboration; counter width is derived from it.
REQ-032 Timeout: when the counter reaches the limit, the block issues frame_err with err_code=3 and returns to IDLE.
REQ-033 If uart_rx_done coincides with timeout expiry, the byte is processed normally, the counter clears, and no timeout is issued.
REQ-034 Payload bytes are streamed before the frame is validated; the consumer discards a frame that ends in frame_err.
REQ-035 A new HDR0 byte is accepted in the cycle after frame_done or frame_err.

Reset
REQ-036 With rst high at a clk edge, the state becomes IDLE.
REQ-037 With rst high at a clk edge, all strobes become 0.
REQ-038 With rst high at a clk edge, pay_data, pay_idx, frame_len, err_code, the accumulator and the timeout counter become 0.
REQ-039 Reset during a frame discards the frame without raising frame_err; uart_rx_done is ignored while rst is high.

Configuration
REQ-040 Macro UART_FRAME_CHKSUM_EN defined: the CHK state and err_code=2 exist as described above.
REQ-041 Macro UART_FRAME_CHKSUM_EN undefined: there is no CHK byte and no accumulator.
REQ-042 Macro UART_FRAME_CHKSUM_EN undefined: frame_done occurs 1 cycle after the uart_rx_done of the last payload byte, and err_code=2 never occurs.

Verification
REQ-043 Send 55 AA 03 11 22 33 69 -> three pay_valid strobes with idx 0..2 and data 11/22/33, then frame_done, frame_len=3.
REQ-044 Send 55 AA 02 01 02 00 -> two payload strobes, then frame_err with err_code=2 and no frame_done; the next good frame passes.
REQ-045 Send 55 AA 00, then 55 AA 11 with MAX_LEN=16 -> frame_err with err_code=1 twice, and no pay_valid.
REQ-046 Send 55 AA 04 01 and then stay idle -> frame_err with err_code=3 exactly at the limit (17361 clocks at the defaults) after byte 01.
REQ-047 Send 55 55 AA 01 7E 7F -> frame accepted; separately, assert rst after 55 AA 02 01 -> no strobes, and the next frame decodes correctly.
REQ-048 Build with UART_FRAME_CHKSUM_EN undefined and send 55 AA 01 5A -> frame_done 1 cycle after the 5A strobe.
